switch_router: RTL and testbench
================================

# switch_router

Parametrised N-port packet switch datapath: one ingress word stream, a runtime-programmable address/mask table with one entry per output port, and a per-port output FIFO. It generalises the fixed 42-port switch to any port count, FIFO depth and data width, and adds multicast (one word to several ports), per-port enable, and backpressure from each output. It sits between the ingress MAC adapter and the per-port egress logic.

## Interface
- NUM_OF_PORTS, 8, number of output ports (2..64)
- PORT_ADDR_LENGTH, 32, width of destination address and table entries
- DATA_WIDTH, 64, payload word width
- FIFO_DEPTH, 4, entries per output FIFO (power of two, ≥2)
- clk  in  1  single clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  ingress word valid
- in_ready  out  1  ingress word accepted when in_valid & in_ready
- in_addr  in  PORT_ADDR_LENGTH  destination address of ingress word
- in_data  in  DATA_WIDTH  ingress payload
- cfg_we  in  1  table write strobe
- cfg_port  in  $clog2(NUM_OF_PORTS)  table entry index
- cfg_addr  in  PORT_ADDR_LENGTH  entry match address
- cfg_mask  in  PORT_ADDR_LENGTH  entry match mask (1 = bit compared)
- cfg_en  in  1  entry enable
- out_valid  out  NUM_OF_PORTS  per-port FIFO non-empty
- out_ready  in  NUM_OF_PORTS  per-port pop
- out_data  out  NUM_OF_PORTS*DATA_WIDTH  port p in bits [p*DATA_WIDTH +: DATA_WIDTH]
- drop_cnt  out  32  unmatched-word counter (only with SWITCH_DROP_CNT_EN)

## Operation
- Match vector: hit[p] = en[p] & ((in_addr & mask[p]) == (addr[p] & mask[p])); purely combinational from current table state.
- in_ready = 1 when hit is zero; otherwise AND over p of (!hit[p] | !full[p]). Depends on table and FIFO state only, never on in_valid.
- Accepted word with hit != 0: pushed into every FIFO p with hit[p] (multicast, all or none).
- Accepted word with hit == 0: consumed and discarded.
- cfg_we: entry cfg_port loaded with cfg_addr/cfg_mask/cfg_en on the clock edge; an ingress word accepted in the same cycle uses the old entry. cfg_port ≥ NUM_OF_PORTS: write ignored.
- FIFO push blocked when full even if the same port pops that cycle (full = count == FIFO_DEPTH). Simultaneous push and pop on a non-full, non-empty FIFO: count unchanged, order preserved.
- Pop: out_valid[p] & out_ready[p]; out_ready while empty ignored.
- Reset: all table entries en=0, addr=0, mask=0; all FIFOs empty (out_valid=0); out_data undefined-but-stable (drive 0); drop_cnt=0; in_ready=1 (no entry enabled, so all traffic drops). Reset mid-traffic discards FIFO contents without emitting partial data.

## Timing
- Ingress accept at edge t → out_valid[p]=1 and out_data valid after edge t (visible in cycle t+1); one-cycle latency.
- Pop at edge t → next word (if any) presented in cycle t+1; back-to-back pops sustain one word/cycle/port.
- in_ready drop due to full is combinational in the same cycle the FIFO reaches full.
- Table write at edge t affects matching from cycle t+1.

## Configuration
- SWITCH_DROP_CNT_EN defined: drop_cnt port exists; increments by 1 on each accepted word with hit == 0; saturates at 32'hFFFF_FFFF; cleared by rst.
- Not defined: drop_cnt port and counter absent; unmatched words still silently discarded.

## Structure
- switch_pkg: NUM_OF_PORTS/PORT_ADDR_LENGTH/DATA_WIDTH defaults, typedef table entry struct {addr, mask, en}, port index width constant.
- Sub-module switch_fifo: single-clock synchronous FIFO (DATA_WIDTH, FIFO_DEPTH), outputs full/empty/head data; instantiated NUM_OF_PORTS times via generate.

## Test plan
- Reset, then in_valid with in_addr=32'h10 → in_ready=1, no out_valid, drop_cnt=1 (macro on).
- Port 2 entry addr=32'h0000_0100 mask=32'hFFFF_FF00 en=1; send addr 32'h0000_0142 data 64'hA5 → out_valid[2]=1 next cycle, out_data port 2 = 64'hA5, others idle.
- Ports 1 and 3 both match addr 32'h0; send one word → both FIFOs hold it; pop port 1 only → port 3 still valid.
- Port 0 out_ready=0, send FIFO_DEPTH+1 words to port 0 → in_ready low after 4th word; raise out_ready → 5th accepted, order 1..5 preserved.
- cfg_we disabling port 2 in same cycle as word to port 2 → word still delivered; next word to port 2 dropped.
- Assert rst with 3 words queued on port 0 → out_valid=0 next cycle, table cleared, subsequent word dropped.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared defaults and the table-entry record for the N-port switch.
// Build option: SWITCH_DROP_CNT_EN adds the unmatched-word counter.
package switch_pkg;
  localparam int SW_NUM_PORTS  = 8;
  localparam int SW_ADDR_W     = 32;
  localparam int SW_DATA_W     = 64;
  localparam int SW_FIFO_DEPTH = 4;
  localparam int SW_PORT_IDX_W = $clog2(SW_NUM_PORTS);

  // Field layout of one address/mask table entry at the default address width.
  typedef struct packed {
    logic [SW_ADDR_W-1:0] addr;
    logic [SW_ADDR_W-1:0] mask;
    logic                 en;
  } tbl_entry_t;
endpackage

// File: rtl/switch_fifo.sv
// Single-clock per-port output FIFO with full/empty flags and head data.
// A push while full is refused even if a pop happens in the same cycle.
module switch_fifo
  import switch_pkg::*;
#(
  parameter int DATA_WIDTH = SW_DATA_W,
  parameter int FIFO_DEPTH = SW_FIFO_DEPTH
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  pop_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wptr_q, rptr_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  do_push, do_pop;

  assign full_o  = (cnt_q == CW'(FIFO_DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end
endmodule

// File: rtl/switch_router.sv
// N-port switch: address/mask match table, multicast push into per-port FIFOs.
// Build option: SWITCH_DROP_CNT_EN exposes drop_cnt (saturating unmatched-word count).
module switch_router
  import switch_pkg::*;
#(
  parameter int NUM_OF_PORTS     = SW_NUM_PORTS,
  parameter int PORT_ADDR_LENGTH = SW_ADDR_W,
  parameter int DATA_WIDTH       = SW_DATA_W,
  parameter int FIFO_DEPTH       = SW_FIFO_DEPTH
)(
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [PORT_ADDR_LENGTH-1:0]        in_addr,
  input  logic [DATA_WIDTH-1:0]              in_data,
  input  logic                               cfg_we,
  input  logic [$clog2(NUM_OF_PORTS)-1:0]    cfg_port,
  input  logic [PORT_ADDR_LENGTH-1:0]        cfg_addr,
  input  logic [PORT_ADDR_LENGTH-1:0]        cfg_mask,
  input  logic                               cfg_en,
  output logic [NUM_OF_PORTS-1:0]            out_valid,
  input  logic [NUM_OF_PORTS-1:0]            out_ready,
  output logic [NUM_OF_PORTS*DATA_WIDTH-1:0] out_data
`ifdef SWITCH_DROP_CNT_EN
  ,
  output logic [31:0]                        drop_cnt
`endif
);
  localparam int IDX_W = $clog2(NUM_OF_PORTS);

  logic [NUM_OF_PORTS-1:0][PORT_ADDR_LENGTH-1:0] addr_q, mask_q;
  logic [NUM_OF_PORTS-1:0]                       en_q;
  logic [NUM_OF_PORTS-1:0]                       hit, full, empty, push;
  logic                                          accept;

  always_comb begin
    hit = '0;
    for (int p = 0; p < NUM_OF_PORTS; p++)
      hit[p] = en_q[p] & ((in_addr & mask_q[p]) == (addr_q[p] & mask_q[p]));
  end

  // Stall only when some matching port is full; unmatched traffic always drains.
  assign in_ready  = &(~hit | ~full);
  assign accept    = in_valid & in_ready;
  assign push      = {NUM_OF_PORTS{accept}} & hit;
  assign out_valid = ~empty;

  // Out-of-range cfg_port matches no index and is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      mask_q <= '0;
      en_q   <= '0;
    end else if (cfg_we) begin
      for (int p = 0; p < NUM_OF_PORTS; p++) begin
        if (cfg_port == IDX_W'(p)) begin
          addr_q[p] <= cfg_addr;
          mask_q[p] <= cfg_mask;
          en_q[p]   <= cfg_en;
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_OF_PORTS; p++) begin : g_port
    switch_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push[p]),
      .wdata_i (in_data),
      .pop_i   (out_ready[p]),
      .full_o  (full[p]),
      .empty_o (empty[p]),
      .rdata_o (out_data[p*DATA_WIDTH +: DATA_WIDTH])
    );
  end

`ifdef SWITCH_DROP_CNT_EN
  logic [31:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (accept && (hit == '0) && (drop_q != 32'hFFFF_FFFF)) drop_d = drop_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) drop_q <= '0;
    else     drop_q <= drop_d;
  end

  assign drop_cnt = drop_q;
`endif
endmodule

// File: tb/tb_switch_router.sv
// Directed bench for switch_router: expected words queued per port, popped by a monitor.
module tb_switch_router;
  localparam int NP = 8;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int FD = 4;

  logic              clk, rst;
  logic              in_valid, in_ready;
  logic [AW-1:0]     in_addr;
  logic [DW-1:0]     in_data;
  logic              cfg_we, cfg_en;
  logic [2:0]        cfg_port;
  logic [AW-1:0]     cfg_addr, cfg_mask;
  logic [NP-1:0]     out_valid, out_ready;
  logic [NP*DW-1:0]  out_data;
`ifdef SWITCH_DROP_CNT_EN
  logic [31:0]       drop_cnt;
`endif

  typedef struct {
    int          port;
    logic [DW-1:0] data;
  } sb_t;
  sb_t sb[$];

  int checks = 0;
  int errors = 0;

  switch_router #(
    .NUM_OF_PORTS     (NP),
    .PORT_ADDR_LENGTH (AW),
    .DATA_WIDTH       (DW),
    .FIFO_DEPTH       (FD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .cfg_we    (cfg_we),
    .cfg_port  (cfg_port),
    .cfg_addr  (cfg_addr),
    .cfg_mask  (cfg_mask),
    .cfg_en    (cfg_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef SWITCH_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input logic [NP-1:0] mask, input logic [DW-1:0] data);
    for (int p = 0; p < NP; p++)
      if (mask[p]) sb.push_back('{p, data});
  endtask

  task automatic cfg(input int port, input logic [AW-1:0] a, input logic [AW-1:0] m, input logic en);
    cfg_we   = 1'b1;
    cfg_port = 3'(port);
    cfg_addr = a;
    cfg_mask = m;
    cfg_en   = en;
    tick();
    cfg_we   = 1'b0;
  endtask

  // Holds the word until accepted (bounded); exp_hit is the hand-computed port set.
  task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NP-1:0] exp_hit);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout: word %h never accepted, expected acceptance", d);
    end else begin
      sb_push(exp_hit, d);
    end
    tick();
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (!rst && out_valid[p] && out_ready[p]) begin
        int idx;
        idx = -1;
        for (int i = 0; i < sb.size(); i++)
          if (idx < 0 && sb[i].port == p) idx = i;
        checks++;
        if (idx < 0) begin
          errors++;
          $display("FAIL pop_port%0d: got %h, expected no word", p, out_data[p*DW +: DW]);
        end else begin
          if (out_data[p*DW +: DW] !== sb[idx].data) begin
            errors++;
            $display("FAIL pop_port%0d: got %h, expected %h", p, out_data[p*DW +: DW], sb[idx].data);
          end
          sb.delete(idx);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0;
    cfg_we = 1'b0; cfg_port = '0; cfg_addr = '0; cfg_mask = '0; cfg_en = 1'b0;
    out_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h1);
`ifdef SWITCH_DROP_CNT_EN
    chk("rst_drop_cnt", 64'(drop_cnt), 64'h0);
`endif

    // Empty table: everything drops.
    send(32'h10, 64'h1, 8'h00);
    chk("drop_out_valid", 64'(out_valid), 64'h0);
`ifdef SWITCH_DROP_CNT_EN
    chk("drop_cnt_1", 64'(drop_cnt), 64'h1);
`endif

    // Masked match on port 2, one-cycle latency.
    cfg(2, 32'h0000_0100, 32'hFFFF_FF00, 1'b1);
    send(32'h0000_0142, 64'hA5, 8'b0000_0100);
    chk("p2_out_valid", 64'(out_valid), 64'h04);
    chk("p2_data", out_data[2*DW +: DW], 64'hA5);
    out_ready[2] = 1'b1; tick(); out_ready[2] = 1'b0;
    chk("p2_drained", 64'(out_valid), 64'h0);

    // Multicast to ports 1 and 3, pop one side only.
    cfg(1, 32'h0, 32'hFFFF_FFFF, 1'b1);
    cfg(3, 32'h0, 32'hFFFF_FFFF, 1'b1);
    send(32'h0, 64'h33, 8'b0000_1010);
    chk("mc_out_valid", 64'(out_valid), 64'h0A);
    out_ready[1] = 1'b1; tick(); out_ready[1] = 1'b0;
    chk("mc_p3_still", 64'(out_valid), 64'h08);
    out_ready[3] = 1'b1; tick(); out_ready[3] = 1'b0;
    chk("mc_drained", 64'(out_valid), 64'h0);

    // Fill port 0 and check backpressure, then drain in order.
    cfg(0, 32'h200, 32'hFFFF_FFFF, 1'b1);
    for (int i = 1; i <= FD; i++) send(32'h200, 64'(i), 8'b0000_0001);
    in_valid = 1'b1; in_addr = 32'h200; in_data = 64'd5;
    #1;
    chk("full_in_ready", 64'(in_ready), 64'h0);
    out_ready[0] = 1'b1;
    send(32'h200, 64'd5, 8'b0000_0001);
    repeat (6) tick();
    out_ready[0] = 1'b0;
    chk("bp_drained", 64'(out_valid), 64'h0);

    // Table write in the same cycle as a matching word: old entry applies.
    cfg_we = 1'b1; cfg_port = 3'd2; cfg_addr = 32'h100; cfg_mask = 32'hFFFF_FF00; cfg_en = 1'b0;
    in_valid = 1'b1; in_addr = 32'h142; in_data = 64'hB6;
    #1;
    chk("cfgrace_in_ready", 64'(in_ready), 64'h1);
    sb_push(8'b0000_0100, 64'hB6);
    tick();
    cfg_we = 1'b0; in_valid = 1'b0;
    chk("cfgrace_out_valid", 64'(out_valid), 64'h04);
    out_ready[2] = 1'b1; tick(); out_ready[2] = 1'b0;
    send(32'h142, 64'hC7, 8'h00);
    chk("disabled_drop", 64'(out_valid), 64'h0);
`ifdef SWITCH_DROP_CNT_EN
    chk("drop_cnt_2", 64'(drop_cnt), 64'h2);
`endif

    // Reset with traffic queued on port 0.
    for (int i = 0; i < 3; i++) send(32'h200, 64'hD0 + 64'(i), 8'b0000_0001);
    chk("pre_rst_valid", 64'(out_valid), 64'h01);
    rst = 1'b1;
    sb.delete();
    tick();
    chk("rst_mid_valid", 64'(out_valid), 64'h0);
    rst = 1'b0;
    send(32'h200, 64'hDD, 8'h00);
    chk("post_rst_drop", 64'(out_valid), 64'h0);
`ifdef SWITCH_DROP_CNT_EN
    chk("post_rst_drop_cnt", 64'(drop_cnt), 64'h1);
`endif

    repeat (2) tick();
    chk("sb_empty", 64'(sb.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
